// File: rtl/jamma_joy_demux_if.sv
// Signal bundle between the JAMMA player-input front-end and its environment.
// The master drives the edge-connector side; the slave is the demultiplexer.
interface jamma_joy_demux_if;
  logic [7:0] JJOY;
  logic [1:0] JCOIN;
  logic [5:0] KBD_JOY;
  logic       JSELECT;
  logic [7:0] joystick1;
  logic [7:0] joystick2;
  logic [1:0] coin;
  logic       sample_strobe;

  modport master (
    output JJOY,
    output JCOIN,
    output KBD_JOY,
    input  JSELECT,
    input  joystick1,
    input  joystick2,
    input  coin,
    input  sample_strobe
  );

  modport slave (
    input  JJOY,
    input  JCOIN,
    input  KBD_JOY,
    output JSELECT,
    output joystick1,
    output joystick2,
    output coin,
    output sample_strobe
  );
endinterface

// File: rtl/jamma_joy_demux.sv
// JAMMA time-multiplexed joystick demux with per-bit debounce, keyboard merge and coin stretching.
// Define JOY_SOCD_EN to resolve opposing directions (up+down, left+right) on the final outputs.
module jamma_joy_demux #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_CNT   = 3,
  parameter int COIN_PULSE_LEN = 16
) (
  input  logic                 pclk,
  input  logic                 reset_n,
  jamma_joy_demux_if.slave     bus
);

  typedef enum logic [1:0] {
    A_SETTLE = 2'd0,
    A_SAMPLE = 2'd1,
    B_SETTLE = 2'd2,
    B_SAMPLE = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] DEB_LIMIT   = 3'(DEBOUNCE_CNT);
  localparam logic [7:0] COIN_LOAD   = 8'(COIN_PULSE_LEN);

  state_t          state_q, state_d;
  logic [3:0]      settle_cnt_q, settle_cnt_d;

  logic [7:0]      jjoy_s1_q, jjoy_s1_d;
  logic [7:0]      jjoy_s2_q, jjoy_s2_d;
  logic [1:0]      jcoin_s1_q, jcoin_s1_d;
  logic [1:0]      jcoin_s2_q, jcoin_s2_d;
  logic [1:0]      jcoin_prev_q, jcoin_prev_d;

  logic [7:0]      deb1_q, deb1_d;
  logic [7:0]      deb2_q, deb2_d;
  logic [7:0][2:0] deb_cnt1_q, deb_cnt1_d;
  logic [7:0][2:0] deb_cnt2_q, deb_cnt2_d;

  logic [1:0][7:0] coin_cnt_q, coin_cnt_d;
  logic            sample_strobe_q, sample_strobe_d;

  logic [7:0]      joy1_merged;

  // One debounce step for a single bit: returns {new_output, new_counter}.
  function automatic logic [3:0] debounce_step(input logic raw, input logic cur,
                                               input logic [2:0] cnt);
    logic [3:0] res;
    if (raw == cur) begin
      res = {cur, 3'd0};
    end else if (cnt + 3'd1 == DEB_LIMIT) begin
      res = {raw, 3'd0};
    end else begin
      res = {cur, cnt + 3'd1};
    end
    return res;
  endfunction

  function automatic logic [7:0] socd_resolve(input logic [7:0] joy);
    logic [7:0] res;
    res = joy;
`ifdef JOY_SOCD_EN
    if (!res[0] && !res[1]) res[1:0] = 2'b11;
    if (!res[2] && !res[3]) res[3:2] = 2'b11;
`endif
    return res;
  endfunction

  always_comb begin
    jjoy_s1_d    = bus.JJOY;
    jjoy_s2_d    = jjoy_s1_q;
    jcoin_s1_d   = bus.JCOIN;
    jcoin_s2_d   = jcoin_s1_q;
    jcoin_prev_d = jcoin_s2_q;
  end

  // Settle/sample sequencer; the settle counter restarts on every state change.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = '0;
    unique case (state_q)
      A_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = A_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      A_SAMPLE: state_d = B_SETTLE;
      B_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = B_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      B_SAMPLE: state_d = A_SETTLE;
      default:  state_d = A_SETTLE;
    endcase
  end

  always_comb begin
    sample_strobe_d = (state_q == A_SAMPLE) || (state_q == B_SAMPLE);
  end

  always_comb begin
    deb1_d     = deb1_q;
    deb2_d     = deb2_q;
    deb_cnt1_d = deb_cnt1_q;
    deb_cnt2_d = deb_cnt2_q;
    if (state_q == A_SAMPLE) begin
      for (int i = 0; i < 8; i++) begin
        {deb1_d[i], deb_cnt1_d[i]} = debounce_step(jjoy_s2_q[i], deb1_q[i], deb_cnt1_q[i]);
      end
    end
    if (state_q == B_SAMPLE) begin
      for (int i = 0; i < 8; i++) begin
        {deb2_d[i], deb_cnt2_d[i]} = debounce_step(jjoy_s2_q[i], deb2_q[i], deb_cnt2_q[i]);
      end
    end
  end

  // A pulse only starts from idle, so edges during an active pulse never retrigger it.
  always_comb begin
    coin_cnt_d = coin_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (coin_cnt_q[i] != 8'd0) begin
        coin_cnt_d[i] = coin_cnt_q[i] - 8'd1;
      end else if (jcoin_prev_q[i] && !jcoin_s2_q[i]) begin
        coin_cnt_d[i] = COIN_LOAD;
      end
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= A_SETTLE;
      settle_cnt_q    <= '0;
      jjoy_s1_q       <= 8'hFF;
      jjoy_s2_q       <= 8'hFF;
      jcoin_s1_q      <= 2'b11;
      jcoin_s2_q      <= 2'b11;
      jcoin_prev_q    <= 2'b11;
      deb1_q          <= 8'hFF;
      deb2_q          <= 8'hFF;
      deb_cnt1_q      <= '0;
      deb_cnt2_q      <= '0;
      coin_cnt_q      <= '0;
      sample_strobe_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      settle_cnt_q    <= settle_cnt_d;
      jjoy_s1_q       <= jjoy_s1_d;
      jjoy_s2_q       <= jjoy_s2_d;
      jcoin_s1_q      <= jcoin_s1_d;
      jcoin_s2_q      <= jcoin_s2_d;
      jcoin_prev_q    <= jcoin_prev_d;
      deb1_q          <= deb1_d;
      deb2_q          <= deb2_d;
      deb_cnt1_q      <= deb_cnt1_d;
      deb_cnt2_q      <= deb_cnt2_d;
      coin_cnt_q      <= coin_cnt_d;
      sample_strobe_q <= sample_strobe_d;
    end
  end

  // Keyboard input is already synchronous and deliberately skips debounce.
  always_comb begin
    joy1_merged = {deb1_q[7:6], deb1_q[5:0] & bus.KBD_JOY};
  end

  assign bus.JSELECT       = (state_q == B_SETTLE) || (state_q == B_SAMPLE);
  assign bus.joystick1     = socd_resolve(joy1_merged);
  assign bus.joystick2     = socd_resolve(deb2_q);
  assign bus.coin          = {coin_cnt_q[1] == 8'd0, coin_cnt_q[0] == 8'd0};
  assign bus.sample_strobe = sample_strobe_q;

endmodule

// File: tb/tb_jamma_joy_demux.sv
// Directed bench for jamma_joy_demux: vector table for demux/merge/SOCD plus
// hand-written sequences for reset timing, debounce, coin pulses and mid-run reset.
module tb_jamma_joy_demux;

`ifdef JOY_SOCD_EN
  localparam bit SOCD = 1'b1;
`else
  localparam bit SOCD = 1'b0;
`endif

  typedef struct {
    logic [7:0] p1;
    logic [7:0] p2;
    logic [5:0] kbd;
    logic [7:0] j1;
    logic [7:0] j2;
    logic [7:0] j1_socd;
    logic [7:0] j2_socd;
  } vec_t;

  logic       pclk;
  logic       reset_n;
  logic [7:0] p1_val;
  logic [7:0] p2_val;
  int         vectors;
  int         miscompares;
  vec_t       vecs[7];

  jamma_joy_demux_if bus ();

  // Splitter model: the bus shows whichever player JSELECT selects.
  assign bus.JJOY = bus.JSELECT ? p2_val : p1_val;

  jamma_joy_demux #(
    .SETTLE_CYCLES (4),
    .DEBOUNCE_CNT  (3),
    .COIN_PULSE_LEN(16)
  ) dut (
    .pclk   (pclk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] p1, input logic [7:0] p2,
                                input logic [5:0] kbd);
    p1_val      = p1;
    p2_val      = p2;
    bus.KBD_JOY = kbd;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk);
    end
    #1;
  endtask

  // Returns 1ns after the edge that starts the player-2 half of a frame.
  task automatic wait_jselect_rise(output bit found);
    logic prev;
    found = 1'b0;
    prev  = bus.JSELECT;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge pclk);
      #1;
      if (bus.JSELECT && !prev) found = 1'b1;
      prev = bus.JSELECT;
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL jselect_rise: got timeout, expected rise within 30 cycles");
    end
  endtask

  task automatic check_release_timing(input string tag, input int cycles);
    for (int k = 1; k <= cycles; k++) begin
      @(posedge pclk);
      #1;
      check_output({tag, "_jselect"}, bus.JSELECT, ((k / 5) % 2) == 1);
      check_output({tag, "_strobe"}, bus.sample_strobe, (k % 5) == 0);
    end
  endtask

  initial begin
    bit         found;
    bit         saw_low;
    int         lat;
    int         first[2];
    int         low_cnt[2];
    int         pulses[2];
    logic [1:0] prev_coin;

    vectors     = 0;
    miscompares = 0;

    vecs[0] = '{8'hFE, 8'h7F, 6'h3F, 8'hFE, 8'h7F, 8'hFE, 8'h7F};
    vecs[1] = '{8'hFF, 8'hFF, 6'h3B, 8'hFB, 8'hFF, 8'hFB, 8'hFF};
    vecs[2] = '{8'hA5, 8'h5A, 6'h3F, 8'hA5, 8'h5A, 8'hA5, 8'h5A};
    vecs[3] = '{8'hFF, 8'hFC, 6'h3F, 8'hFF, 8'hFC, 8'hFF, 8'hFF};
    vecs[4] = '{8'hF3, 8'h00, 6'h3F, 8'hF3, 8'h00, 8'hFF, 8'h0F};
    vecs[5] = '{8'hFF, 8'hFF, 6'h3C, 8'hFC, 8'hFF, 8'hFF, 8'hFF};
    vecs[6] = '{8'h7E, 8'hFF, 6'h3D, 8'h7C, 8'hFF, 8'h7F, 8'hFF};

    reset_n   = 1'b0;
    bus.JCOIN = 2'b11;
    apply_stimulus(8'h00, 8'h00, 6'h3F);
    wait_cycles(3);
    check_output("rst_joy1", bus.joystick1, 8'hFF);
    check_output("rst_joy2", bus.joystick2, 8'hFF);
    check_output("rst_coin", bus.coin, 2'b11);
    check_output("rst_jselect", bus.JSELECT, 1'b0);
    check_output("rst_strobe", bus.sample_strobe, 1'b0);

    reset_n = 1'b1;
    check_release_timing("release", 15);

    $display("[TB] applying vector table");
    for (int v = 0; v < 7; v++) begin
      apply_stimulus(vecs[v].p1, vecs[v].p2, vecs[v].kbd);
      wait_cycles(40);
      check_output($sformatf("vec%0d_joy1", v), bus.joystick1,
                   SOCD ? vecs[v].j1_socd : vecs[v].j1);
      check_output($sformatf("vec%0d_joy2", v), bus.joystick2,
                   SOCD ? vecs[v].j2_socd : vecs[v].j2);
    end

    // Glitch on fire1 lasting exactly two player-1 samples must be rejected.
    apply_stimulus(8'hFF, 8'hFF, 6'h3F);
    wait_cycles(40);
    wait_jselect_rise(found);
    saw_low = 1'b0;
    apply_stimulus(8'hEF, 8'hFF, 6'h3F);
    for (int i = 0; i < 20; i++) begin
      @(posedge pclk);
      #1;
      if (!bus.joystick1[4]) saw_low = 1'b1;
    end
    apply_stimulus(8'hFF, 8'hFF, 6'h3F);
    for (int i = 0; i < 40; i++) begin
      @(posedge pclk);
      #1;
      if (!bus.joystick1[4]) saw_low = 1'b1;
    end
    check_output("glitch_reject", saw_low, 1'b0);

    // Held for three samples: third player-1 sample lands 30 cycles after the B half starts.
    wait_jselect_rise(found);
    apply_stimulus(8'hEF, 8'hFF, 6'h3F);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge pclk);
      #1;
      if (!bus.joystick1[4] && lat == 0) lat = k;
    end
    check_output("hold_latency", lat, 30);
    check_output("hold_joy1", bus.joystick1, 8'hEF);
    check_output("hold_joy2", bus.joystick2, 8'hFF);

    apply_stimulus(8'hFF, 8'hFF, 6'h3F);
    wait_cycles(40);
    @(negedge pclk);
    bus.KBD_JOY = 6'b111011;
    @(posedge pclk);
    #1;
    check_output("kbd_joy1", bus.joystick1, 8'hFB);
    check_output("kbd_joy2", bus.joystick2, 8'hFF);
    bus.KBD_JOY = 6'h3F;

    // Coin: both channels fall together; coin[1] re-toggles mid-pulse, then fires again later.
    for (int b = 0; b < 2; b++) begin
      first[b]   = 0;
      low_cnt[b] = 0;
      pulses[b]  = 0;
    end
    prev_coin = 2'b11;
    @(posedge pclk);
    #1;
    bus.JCOIN = 2'b00;
    for (int k = 1; k <= 120; k++) begin
      @(posedge pclk);
      #1;
      for (int b = 0; b < 2; b++) begin
        if (!bus.coin[b]) begin
          low_cnt[b]++;
          if (first[b] == 0) first[b] = k;
          if (prev_coin[b]) pulses[b]++;
        end
      end
      prev_coin = bus.coin;
      case (k)
        5:   bus.JCOIN[1] = 1'b1;
        6:   bus.JCOIN[1] = 1'b0;
        8:   bus.JCOIN[1] = 1'b1;
        40:  bus.JCOIN[1] = 1'b0;
        70:  bus.JCOIN[1] = 1'b1;
        100: bus.JCOIN[0] = 1'b1;
        default: ;
      endcase
    end
    check_output("coin0_start", first[0], 3);
    check_output("coin0_len", low_cnt[0], 16);
    check_output("coin0_pulses", pulses[0], 1);
    check_output("coin1_start", first[1], 3);
    check_output("coin1_len", low_cnt[1], 32);
    check_output("coin1_pulses", pulses[1], 2);

    // Reset asserted mid-frame and mid-pulse.
    apply_stimulus(8'hA5, 8'h5A, 6'h3F);
    wait_cycles(40);
    bus.JCOIN = 2'b10;
    wait_cycles(6);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("midrst_joy1", bus.joystick1, 8'hFF);
    check_output("midrst_joy2", bus.joystick2, 8'hFF);
    check_output("midrst_coin", bus.coin, 2'b11);
    check_output("midrst_jselect", bus.JSELECT, 1'b0);
    check_output("midrst_strobe", bus.sample_strobe, 1'b0);
    bus.JCOIN = 2'b11;
    @(posedge pclk);
    #1;
    reset_n = 1'b1;
    check_release_timing("rerelease", 10);
    check_output("rerelease_joy1", bus.joystick1, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/jamma_joy_demux.md
Name: jamma_joy_demux

Overview:
Front-end for the JAMMA edge connector's time-multiplexed player inputs, sitting directly upstream of the arcade core's I_JOYSTICK_A/B, I_PLAYER and I_COIN inputs. It drives the external splitter select line and synchronizes the shared 8-bit JJOY bus. It demultiplexes the bus into two per-player registers with per-bit debounce, merges the PS/2 keyboard joystick into player 1, and stretches coin inputs into clean fixed-length pulses. All inputs and outputs are active-low (0 = pressed).

Parameters:
SETTLE_CYCLES, 4, cycles JSELECT is held before each sample; legal range 3..15
DEBOUNCE_CNT, 3, consecutive differing samples required before a joystick bit changes; legal range 1..7
COIN_PULSE_LEN, 16, coin output low-time in cycles; legal range 2..255

Ports:
pclk  in  1  core pixel clock; sole clock
reset_n  in  1  asynchronous active-low reset
JJOY  in  8  muxed JAMMA bus, asynchronous; bit0 up, 1 down, 2 left, 3 right, 4 fire1, 5 fire2, 6 spare, 7 start
JCOIN  in  2  coin switches, asynchronous, active-low
KBD_JOY  in  6  keyboard joystick, already in the pclk domain, active-low, same bit order as JJOY[5:0]
JSELECT  out  1  splitter select; 0 = player 1 on the bus, 1 = player 2
joystick1  out  8  debounced player 1; bits [5:0] ANDed with KBD_JOY
joystick2  out  8  debounced player 2
coin  out  2  stretched coin pulses, active-low
sample_strobe  out  1  one-cycle high when either player register is updated

Behaviour:
- Reset values (asynchronous, on reset_n=0): JSELECT=0; joystick1=joystick2=8'hFF; coin=2'b11; sample_strobe=0; FSM=A_SETTLE; all counters 0; synchronizer flops 1.
- Sync: JJOY and JCOIN each pass through a 2-flop synchronizer. Every sample is taken from stage 2.
- FSM, four states:
  - A_SETTLE (JSELECT=0): count SETTLE_CYCLES cycles, then go to A_SAMPLE.
  - A_SAMPLE (JSELECT=0, one cycle): capture sync JJOY as the player 1 raw sample, then go to B_SETTLE.
  - B_SETTLE / B_SAMPLE: same as the A states with JSELECT=1 and player 2.
  - B_SAMPLE returns to A_SETTLE.
- Frame period = 2*(SETTLE_CYCLES+1) cycles. JSELECT toggles only on the SAMPLE->SETTLE transition.
- The settle counter clears on every state change.
- Debounce, per bit per player, with a 3-bit counter:
  - If the raw bit equals the output bit, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CNT, the output bit takes the raw value and the counter clears.
  - Counters advance only in that player's SAMPLE cycle.
  - Latency from a stable bus change to the output is at most DEBOUNCE_CNT frames plus 3 cycles.
- joystick1 output = {deb1[7:6], deb1[5:0] & KBD_JOY}. The KBD_JOY path is combinational and bypasses debounce.
- sample_strobe is registered high for one cycle, the cycle after each SAMPLE state.
- Coin channel (independent per bit):
  - A falling edge of sync JCOIN loads the pulse counter with COIN_PULSE_LEN and drives the coin bit low.
  - The counter decrements each cycle; the coin bit returns high when the counter reaches 0.
  - Edges seen while a pulse is active are ignored (no retrigger). A held-low switch produces exactly one pulse.
  - A new pulse requires sync JCOIN to return high for at least one cycle.
- Simultaneous coin edges on both channels are handled independently.
- Reset asserted mid-frame or mid-pulse returns everything to the reset values. Sequencing restarts at A_SETTLE after reset_n deasserts.

Optional Feature:
JOY_SOCD_EN. When defined, the final joystick outputs (after keyboard merge) resolve opposing directions: up+down both low -> both forced high; left+right both low -> both forced high. Other bits are unaffected. When undefined, opposing directions pass through unchanged.

Test Plan:
- Reset: hold reset_n=0 with JJOY=8'h00 -> joystick1=joystick2=8'hFF, coin=2'b11, JSELECT=0. After release, JSELECT first goes high at cycle 5 (SETTLE_CYCLES=4) and toggles every 5 cycles thereafter.
- Demux: bus model returns 8'hFE when JSELECT=0 and 8'h7F when JSELECT=1 -> after 3 frames plus sync latency, joystick1=8'hFE and joystick2=8'h7F, with no cross-talk.
- Debounce: player 1 bit4 glitches low for 2 frames then returns high (DEBOUNCE_CNT=3) -> joystick1[4] stays 1. Held low for 3 frames -> joystick1[4]=0 within 3 frames + 3 cycles.
- Keyboard merge: JJOY idle 8'hFF, KBD_JOY=6'b111011 -> joystick1=8'hFB on the next cycle; joystick2=8'hFF.
- Coin: JCOIN[0] low for 100 cycles -> exactly one coin[0] low pulse of 16 cycles, starting 3 cycles after the edge. Toggling JCOIN[1] at cycle 5 of an active pulse -> no extension.
- SOCD (JOY_SOCD_EN defined): player 2 bus 8'hFC (up+down) -> joystick2=8'hFF. With the macro undefined -> joystick2=8'hFC.
